// File: rtl/axis_velocity_estimator.sv
// axis_velocity_estimator
// Turns a signed position stream into a decimated velocity stream: every
// 2^L accepted samples it emits (newest position - window reference position)
// on an AXI4-Stream master with backpressure. L is clamped to
// MAX_LOG_DECIMATION. It is re-latched only at reset and at window boundaries,
// so mid-window changes wait for the next boundary. Results that arrive while
// an earlier one is still waiting to transfer are dropped, and overrun is then
// set sticky.

module axis_velocity_estimator #(
    parameter int S_AXIS_TDATA_WIDTH = 32,
    parameter int M_AXIS_TDATA_WIDTH = 32,
    parameter int MAX_LOG_DECIMATION = 16
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [4:0]                    log_decimation,
    input  logic                          S_AXIS_tvalid,
    input  logic [S_AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    output logic                          M_AXIS_tvalid,
    input  logic                          M_AXIS_tready,
    output logic [M_AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    output logic                          overrun
);

    // One extra bit so that 2^MAX_LOG_DECIMATION is representable while the
    // last-sample index (2^L - 1) is formed.
    localparam int CNT_W = MAX_LOG_DECIMATION + 1;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Clamp the requested log window length to the supported maximum.
    function automatic logic [4:0] clamp_log(input logic [4:0] ld);
        logic [4:0] res;
        if (ld > 5'(MAX_LOG_DECIMATION)) begin
            res = 5'(MAX_LOG_DECIMATION);
        end else begin
            res = ld;
        end
        return res;
    endfunction

    state_t                          state_r;
    logic [4:0]                      win_log_r;
    logic [CNT_W-1:0]                cnt_r;
    logic [S_AXIS_TDATA_WIDTH-1:0]   pos_ref_r;
    logic                            tvalid_r;
    logic [M_AXIS_TDATA_WIDTH-1:0]   tdata_r;
    logic                            overrun_r;

    logic [CNT_W-1:0]                window_last_s;
    logic                            window_end_s;
    logic                            hold_blocked_s;
    logic [S_AXIS_TDATA_WIDTH-1:0]   delta_s;

    // Window boundary detection, wrap-around difference, and output-slot status.
    always_comb begin
        window_last_s  = (CNT_W'(1) << win_log_r) - CNT_W'(1);
        delta_s        = S_AXIS_tdata - pos_ref_r;
        hold_blocked_s = tvalid_r & ~M_AXIS_tready;
        if ((state_r == ST_RUN) && S_AXIS_tvalid && (cnt_r == window_last_s)) begin
            window_end_s = 1'b1;
        end else begin
            window_end_s = 1'b0;
        end
    end

    // Sample-acceptance FSM, window counter/reference, and registered output slot.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r   <= ST_INIT;
            win_log_r <= clamp_log(log_decimation);
            cnt_r     <= '0;
            pos_ref_r <= '0;
            tvalid_r  <= 1'b0;
            tdata_r   <= '0;
            overrun_r <= 1'b0;
        end else begin
            // A completed handshake frees the slot; a new result below may refill it.
            if (tvalid_r && M_AXIS_tready) begin
                tvalid_r <= 1'b0;
            end

            case (state_r)
                ST_INIT: begin
                    if (S_AXIS_tvalid) begin
                        pos_ref_r <= S_AXIS_tdata;
                        cnt_r     <= '0;
                        state_r   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (window_end_s) begin
                        pos_ref_r <= S_AXIS_tdata;
                        cnt_r     <= '0;
                        win_log_r <= clamp_log(log_decimation);
                        if (hold_blocked_s) begin
                            // Held result has not transferred: keep it, drop the new one.
                            overrun_r <= 1'b1;
                        end else begin
                            tvalid_r <= 1'b1;
                            tdata_r  <= M_AXIS_TDATA_WIDTH'(delta_s);
                        end
                    end else if (S_AXIS_tvalid) begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_INIT;
                end
            endcase
        end
    end

    assign M_AXIS_tvalid = tvalid_r;
    assign M_AXIS_tdata  = tdata_r;
    assign overrun       = overrun_r;

endmodule
